uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: the transmit-side counterpart of the peripheral UART receiver. Accepts bytes from the core over a valid/ready handshake, buffers them in a small FIFO, and serialises each as one start bit, 8 data bits LSB-first and one stop bit on `tx_pin`. It sits in the peripheral block beside the receiver and shares its baud parameters.

## Interface
- `CLK_FREQUENCY`, 50: clock frequency in MHz.
- `BAUD_RATE`, 115200: serial baud rate.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥ 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `tx_data`  in  8  byte to send.
- `tx_data_valid`  in  1  `tx_data` is valid.
- `tx_data_ready`  out  1  FIFO can accept a byte.
- `tx_busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `tx_pin`  out  1  serial data output; idle high.

## Operation
- Derived constant: `CYCLE = CLK_FREQUENCY*1000000/BAUD_RATE`. Required range: 2 ≤ CYCLE ≤ 65535.
- Push handshake: a byte is accepted on a rising edge with `tx_data_valid && tx_data_ready`.
  - `tx_data_ready = !fifo_full`.
  - When not ready, the source holds `tx_data` and valid; nothing is dropped.
- Pop rule: a pop in the same cycle as a push is legal. The push is gated only by full.
- State machine:
  - S_IDLE: if the FIFO is non-empty, pop the head into an 8-bit shift register and go to S_START. Otherwise stay.
  - S_START: `tx_pin` = 0 for CYCLE clocks, then go to S_SEND_BYTE.
  - S_SEND_BYTE: `tx_pin` = `shift[0]` for CYCLE clocks per bit.
    - Shift right at each bit boundary.
    - A 3-bit `bit_cnt` counts bits; after bit 7 completes, go to S_STOP.
  - S_STOP: `tx_pin` = 1 for CYCLE clocks, then go to S_IDLE.
- Counters:
  - 16-bit `cycle_cnt` clears on every state change and at each bit boundary. Otherwise it increments.
  - `bit_cnt` is zero outside S_SEND_BYTE.
- Output register: `tx_pin` is driven from a register (glitch-free). Its value follows the state entered on that edge.
- `tx_busy = (state != S_IDLE) || !fifo_empty`.
- Reset (asserted at any time, including mid-frame):
  - `tx_pin` goes to 1 immediately.
  - The FIFO is flushed.
  - State returns to S_IDLE.
  - `cycle_cnt` and `bit_cnt` clear.
  - The partial frame is abandoned.
- Reset values: `tx_pin` = 1, `tx_data_ready` = 1, `tx_busy` = 0.

## Timing
- Accept edge N (FIFO empty, S_IDLE): the FIFO is non-empty at N+1. The pop and the `tx_pin` fall both occur at edge N+1.
  - Latency from accept to start-bit edge: 1 clock.
- Frame length: exactly 10·CYCLE clocks, measured from the start-bit fall to the end of the stop bit.
- Back-to-back frames: exactly 1 idle clock (S_IDLE, pin high) separates the stop bit from the next start bit. Line time per byte is 10·CYCLE + 1.
- Capacity: the FIFO holds FIFO_DEPTH bytes plus one byte in the shift register. At most FIFO_DEPTH+1 bytes are accepted before the first completes.
- `tx_data_ready` falls combinationally with full. It rises in the cycle after the pop that leaves the FIFO non-full.

## Structure
- Shared UART package holds:
  - state encodings S_IDLE, S_START, S_SEND_BYTE, S_STOP;
  - the CYCLE computation, shared with the receiver;
  - the frame constants: 8 data bits, 1 stop bit.
- One sub-module, `uart_tx_fifo`:
  - synchronous single-clock FIFO with async active-low reset;
  - pointers of width log2(FIFO_DEPTH)+1;
  - outputs full and empty, with show-ahead read data.

## Test plan
All scenarios use CLK_FREQUENCY=50, BAUD_RATE=115200 (CYCLE=434), FIFO_DEPTH=4.
1. Reset: assert rst_n=0 -> `tx_pin`=1, `tx_data_ready`=1, `tx_busy`=0. Release; idle for 1000 clocks -> `tx_pin` stays 1.
2. Single byte 0x55 -> pin falls 1 clock after accept.
   - 434 clocks low.
   - Bits 1,0,1,0,1,0,1,0 at 434 clocks each.
   - 434 clocks high.
   - `tx_busy` drops at the end of the stop bit.
3. Burst 0x00, 0xFF, 0xA5, 0x3C pushed on consecutive clocks -> four frames decoded correctly. Gaps between frames are exactly 1 clock. Total span is 4·4340 + 3 clocks.
4. Overfill: hold valid with 7 bytes -> 5 accepted, then `tx_data_ready`=0.
   - Ready reasserts 1 clock after the next pop.
   - All 7 bytes are transmitted in order, with no loss or duplication.
5. Reset mid-frame during bit 3 of 0x81, with 2 bytes queued -> `tx_pin`=1 immediately. FIFO empty, `tx_busy`=0. No further frames after release.
6. Push and pop in the same cycle with FIFO full-1 -> FIFO count is unchanged, and byte order is preserved.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// the clocks-per-bit computation also used by the receiver.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_SEND_BYTE = 2'd2,
      S_STOP      = 2'd3
   } uart_state_t;

   localparam int unsigned DATA_BITS = 32'd8;
   localparam int unsigned STOP_BITS = 32'd1;

   // Clocks per bit for a clock given in MHz; truncates like the receiver does.
   function automatic int unsigned calc_cycle(input int unsigned clk_mhz,
                                              input int unsigned baud);
      longint unsigned clk_hz;
      clk_hz = 64'(clk_mhz) * 64'd1000000;
      return 32'(clk_hz / 64'(baud));
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO with show-ahead read data. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer registers; reset flushes the FIFO by equalising them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Serial UART transmitter: bytes queued through a small FIFO are sent as
// one start bit, eight data bits LSB-first and one stop bit on tx_pin.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 50,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ready,
   output logic       tx_busy,
   output logic       tx_pin
);

   localparam int unsigned CYCLE      = calc_cycle(CLK_FREQUENCY, BAUD_RATE);
   localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 32'd1);
   localparam logic [2:0]  BIT_LAST   = 3'(DATA_BITS - 32'd1);

   uart_state_t state_r;
   uart_state_t state_s;
   logic [15:0] cycle_cnt_r;
   logic [15:0] cycle_cnt_s;
   logic [2:0]  bit_cnt_r;
   logic [2:0]  bit_cnt_s;
   logic [7:0]  shift_r;
   logic [7:0]  shift_s;
   logic        tx_pin_r;
   logic        pin_s;
   logic        pop_s;
   logic        push_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic [7:0]  fifo_head_s;

   assign push_s        = tx_data_valid && !fifo_full_s;
   assign tx_data_ready = !fifo_full_s;
   assign tx_busy       = (state_r != S_IDLE) || !fifo_empty_s;
   assign tx_pin        = tx_pin_r;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32'd8)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (tx_data),
      .pop       (pop_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Next-state, counter and shift-register logic for the frame sequencer.
   always_comb begin
      state_s     = state_r;
      cycle_cnt_s = cycle_cnt_r + 16'd1;
      bit_cnt_s   = bit_cnt_r;
      shift_s     = shift_r;
      pop_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            cycle_cnt_s = 16'd0;
            bit_cnt_s   = 3'd0;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_s = fifo_head_s;
               state_s = S_START;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (cycle_cnt_r == CYCLE_LAST) begin
               state_s     = S_SEND_BYTE;
               cycle_cnt_s = 16'd0;
            end else begin
               state_s = S_START;
            end
         end
         S_SEND_BYTE: begin
            if (cycle_cnt_r == CYCLE_LAST) begin
               cycle_cnt_s = 16'd0;
               if (bit_cnt_r == BIT_LAST) begin
                  state_s   = S_STOP;
                  bit_cnt_s = 3'd0;
               end else begin
                  bit_cnt_s = bit_cnt_r + 3'd1;
                  shift_s   = {1'b0, shift_r[7:1]};
               end
            end else begin
               state_s = S_SEND_BYTE;
            end
         end
         S_STOP: begin
            if (cycle_cnt_r == CYCLE_LAST) begin
               state_s     = S_IDLE;
               cycle_cnt_s = 16'd0;
            end else begin
               state_s = S_STOP;
            end
         end
         default: begin
            state_s     = S_IDLE;
            cycle_cnt_s = 16'd0;
            bit_cnt_s   = 3'd0;
         end
      endcase
   end

   // The pin register reflects the state being entered, so it changes on the same edge.
   always_comb begin
      pin_s = 1'b1;
      case (state_s)
         S_START:     pin_s = 1'b0;
         S_SEND_BYTE: pin_s = shift_s[0];
         default:     pin_s = 1'b1;
      endcase
   end

   // Sequencer state, counters, shift register and glitch-free pin register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         cycle_cnt_r <= 16'd0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         tx_pin_r    <= 1'b1;
      end else begin
         state_r     <= state_s;
         cycle_cnt_r <= cycle_cnt_s;
         bit_cnt_r   <= bit_cnt_s;
         shift_r     <= shift_s;
         tx_pin_r    <= pin_s;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a frame-timeline model checked every cycle,
// a line decoder, and hand-computed timing points for each scenario.
module tb_uart_tx;

   localparam int CYC   = 434;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CYC;
   localparam int SLOT  = FRAME + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_data_valid = 1'b0;
   logic       tx_data_ready;
   logic       tx_busy;
   logic       tx_pin;

   int vec = 0;
   int err = 0;
   int cyc = 0;

   uart_tx #(
      .CLK_FREQUENCY (50),
      .BAUD_RATE     (115200),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .tx_busy       (tx_busy),
      .tx_pin        (tx_pin)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a queue of accepted bytes and the age of the frame on the line.
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_byte = 8'h00;

   function automatic logic exp_pin();
      int idx;
      if (!m_active) return 1'b1;
      idx = m_pos / CYC;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_byte[idx-1];
      return 1'b1;
   endfunction

   initial forever begin
      bit push_ok;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_q.delete();
         m_active = 1'b0;
         m_pos = 0;
      end else begin
         push_ok = tx_data_valid && (m_q.size() < DEPTH);
         if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 1'b0;
         end else if (m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_active = 1'b1;
            m_pos = 0;
         end
         if (push_ok) m_q.push_back(tx_data);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      check("pin", tx_pin, exp_pin());
      check("ready", tx_data_ready, m_q.size() < DEPTH);
      check("busy", tx_busy, m_active || (m_q.size() != 0));
   end

   // Line decoder: samples mid-bit relative to each detected start edge.
   logic [7:0] rx_q[$];
   int         starts[$];
   int         framing_err = 0;
   bit         d_on = 1'b0;
   int         d_t = 0;
   logic [7:0] d_b = 8'h00;

   initial forever begin
      int k;
      @(negedge clk);
      if (!rst_n) begin
         d_on = 1'b0;
      end else if (!d_on) begin
         if (tx_pin === 1'b0) begin
            d_on = 1'b1;
            d_t = 0;
            starts.push_back(cyc);
         end
      end else begin
         d_t++;
         if (d_t >= CYC && (d_t - CYC / 2) % CYC == 0) begin
            k = (d_t - CYC / 2) / CYC;
            if (k <= 8) begin
               d_b[k-1] = tx_pin;
            end else begin
               if (tx_pin !== 1'b1) framing_err++;
               rx_q.push_back(d_b);
            end
         end
         if (d_t == FRAME - 1) d_on = 1'b0;
      end
   end

   task automatic push(input logic [7:0] b, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      tx_data = b;
      tx_data_valid = 1'b1;
      while (tx_data_ready !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic idle_bus();
      @(negedge clk);
      tx_data_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_rx(input string name, input logic [7:0] exp);
      if (rx_q.size() == 0) check(name, 32'hDEAD, exp);
      else check(name, rx_q.pop_front(), exp);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached with %0d vectors, %0d miscompares", vec, err);
      $fatal(1, "watchdog");
   end

   initial begin
      int a[7];
      int ae;
      logic [7:0] burst[4];
      logic [7:0] over[7];
      logic [7:0] ord[5];
      burst = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
      over  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD};
      ord   = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h99};

      // 1: reset values, then a long idle line
      #1 rst_n = 1'b0;
      #2;
      check("rst_pin", tx_pin, 1'b1);
      check("rst_ready", tx_data_ready, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      check("idle_pin", tx_pin, 1'b1);
      check("idle_frames", starts.size(), 0);

      // 2: single 0x55 frame, timing pinned by hand
      starts.delete();
      push(8'h55, a[0]);
      check("s2_pin_at_accept", tx_pin, 1'b1);
      check("s2_busy_at_accept", tx_busy, 1'b1);
      idle_bus();
      wait_cyc(a[0] + 1);    check("s2_start_fall", tx_pin, 1'b0);
      wait_cyc(a[0] + 434);  check("s2_start_end", tx_pin, 1'b0);
      wait_cyc(a[0] + 435);  check("s2_bit0", tx_pin, 1'b1);
      wait_cyc(a[0] + 869);  check("s2_bit1", tx_pin, 1'b0);
      wait_cyc(a[0] + 3907); check("s2_stop", tx_pin, 1'b1);
      wait_cyc(a[0] + 4340); check("s2_busy_in_stop", tx_busy, 1'b1);
      wait_cyc(a[0] + 4341); check("s2_busy_after", tx_busy, 1'b0);
      check("s2_start_cycle", starts[0], a[0] + 1);
      check_rx("s2_byte", 8'h55);

      // 3: four-byte burst on consecutive clocks
      starts.delete();
      for (int i = 0; i < 4; i++) push(burst[i], a[i]);
      idle_bus();
      check("s3_consecutive", a[3] - a[0], 3);
      wait_cyc(a[0] + 4 * SLOT + 5);
      for (int i = 0; i < 4; i++) check_rx("s3_byte", burst[i]);
      check("s3_frames", starts.size(), 4);
      if (starts.size() == 4) begin
         for (int i = 0; i < 3; i++) check("s3_gap", starts[i+1] - starts[i], SLOT);
         check("s3_span", starts[3] + FRAME - starts[0], 4 * 4340 + 3);
      end
      check("s3_busy_end", tx_busy, 1'b0);

      // 4: overfill with valid held; capacity is FIFO plus shift register
      starts.delete();
      for (int i = 0; i < 5; i++) push(over[i], a[i]);
      check("s4_five_accepted", a[4] - a[0], 4);
      check("s4_ready_low", tx_data_ready, 1'b0);
      push(over[5], a[5]);
      check("s4_ready_rise", a[5] - a[0], 4343);
      push(over[6], a[6]);
      check("s4_seventh", a[6] - a[0], 4343 + SLOT);
      idle_bus();
      wait_cyc(a[0] + 1 + 7 * SLOT + 5);
      for (int i = 0; i < 7; i++) check_rx("s4_byte", over[i]);
      check("s4_frames", starts.size(), 7);
      check("s4_extra", rx_q.size(), 0);

      // 5: reset during bit 3 of 0x81 with two bytes queued
      starts.delete();
      push(8'h81, a[0]);
      push(8'h11, a[1]);
      push(8'h22, a[2]);
      idle_bus();
      wait_cyc(a[0] + 1 + 4 * CYC + 200);
      check("s5_bit3_low", tx_pin, 1'b0);
      check("s5_busy_before", tx_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_pin", tx_pin, 1'b1);
      check("s5_rst_ready", tx_data_ready, 1'b1);
      check("s5_rst_busy", tx_busy, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      check("s5_no_frames", rx_q.size(), 0);
      check("s5_one_start", starts.size(), 1);
      check("s5_busy_after", tx_busy, 1'b0);

      // 6: push lands on the pop edge while the FIFO holds three bytes
      starts.delete();
      push(ord[0], a[0]);
      for (int i = 1; i < 4; i++) push(ord[i], a[i]);
      idle_bus();
      check("s6_not_full", tx_data_ready, 1'b1);
      wait_cyc(a[0] + 4340);
      push(ord[4], ae);
      check("s6_push_on_pop", ae, a[0] + 4342);
      check("s6_ready_kept", tx_data_ready, 1'b1);
      check("s6_next_start", tx_pin, 1'b0);
      idle_bus();
      wait_cyc(a[0] + 1 + 5 * SLOT + 5);
      for (int i = 0; i < 5; i++) check_rx("s6_byte", ord[i]);
      check("s6_frames", starts.size(), 5);
      if (starts.size() >= 2) check("s6_second_start", starts[1], a[0] + 4342);

      check("framing", framing_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
